// File: rtl/lpddr2_multiport_bridge.sv
// rtl/lpddr2_multiport_bridge.sv - multi-requester arbiter onto one LPDDR2 Avalon-MM master
//
// Ports:
//   iCLK, iRST_n          afi_half_clk and synchronous active-low reset
//   local_init_done       controller calibration complete
//   port_rreq/port_wreq   per-port level requests, held until port_done
//   port_addr/port_wdata  packed per-port byte address and write data
//   port_rdata            packed per-port read data holding registers
//   port_done/port_err    one-cycle completion pulse and read-timeout flag
//   avl_*                 Avalon-MM master towards the LPDDR2 controller
//   c_state               current FSM state (1 = ready)
module lpddr2_multiport_bridge #(
  parameter int NUM_PORTS  = 2,
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int AVL_ADDR_W = 27,
  parameter int WORD_SHIFT = 2,
  parameter int ARB_MODE   = 0,
  parameter int RD_TIMEOUT = 1023
) (
  input  logic                        iCLK,
  input  logic                        iRST_n,
  input  logic                        local_init_done,
  input  logic [NUM_PORTS-1:0]        port_rreq,
  input  logic [NUM_PORTS-1:0]        port_wreq,
  input  logic [NUM_PORTS*ADDR_W-1:0] port_addr,
  input  logic [NUM_PORTS*DATA_W-1:0] port_wdata,
  output logic [NUM_PORTS*DATA_W-1:0] port_rdata,
  output logic [NUM_PORTS-1:0]        port_done,
  output logic [NUM_PORTS-1:0]        port_err,
  input  logic                        avl_waitrequest_n,
  output logic [AVL_ADDR_W-1:0]       avl_address,
  output logic                        avl_read,
  output logic                        avl_write,
  output logic                        avl_burstbegin,
  output logic [DATA_W-1:0]           avl_writedata,
  input  logic                        avl_readdatavalid,
  input  logic [DATA_W-1:0]           avl_readdata,
  output logic [3:0]                  c_state
);

  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CNT_W = $clog2(RD_TIMEOUT + 1);
  localparam logic [IDX_W+1:0] NP_W      = (IDX_W + 2)'(NUM_PORTS);
  localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(NUM_PORTS - 1);

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_IDLE   = 4'd1,
    S_ISSUE  = 4'd2,
    S_RDWAIT = 4'd3,
    S_DONE   = 4'd4
  } state_t;

  state_t                           r_state;
  state_t                           w_state_nxt;
  logic [IDX_W-1:0]                 r_grant;
  logic [IDX_W-1:0]                 r_last_grant;
  logic                             r_is_write;
  logic [AVL_ADDR_W-1:0]            r_avl_address;
  logic [DATA_W-1:0]                r_avl_writedata;
  logic                             r_avl_read;
  logic                             r_avl_write;
  logic                             r_avl_burstbegin;
  logic [CNT_W-1:0]                 r_cnt;
  logic [NUM_PORTS-1:0][DATA_W-1:0] r_rdata;
  logic [NUM_PORTS-1:0]             r_done;
  logic [NUM_PORTS-1:0]             r_err;

  logic [NUM_PORTS-1:0]             w_req;
  logic [NUM_PORTS-1:0][ADDR_W-1:0] w_addr_arr;
  logic [NUM_PORTS-1:0][DATA_W-1:0] w_wdata_arr;
  logic                             w_gnt_valid;
  logic [IDX_W-1:0]                 w_gnt_idx;
  logic [IDX_W-1:0]                 w_cand;
  logic [IDX_W+1:0]                 w_sum;
  logic                             w_timeout;

  assign w_req       = port_rreq | port_wreq;
  assign w_addr_arr  = port_addr;
  assign w_wdata_arr = port_wdata;
  // One cycle before the counter would reach RD_TIMEOUT, so exactly
  // RD_TIMEOUT RDWAIT cycles elapse before the error completion.
  assign w_timeout   = (r_cnt == CNT_W'(RD_TIMEOUT - 1));

  // Candidate order: round-robin starts after the last grant and wraps,
  // fixed priority walks upward from index 0. First requester wins.
  always_comb begin
    w_gnt_valid = 1'b0;
    w_gnt_idx   = '0;
    w_cand      = '0;
    w_sum       = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (ARB_MODE == 1) begin
        w_cand = IDX_W'(i);
      end else begin
        w_sum = {2'b00, r_last_grant} + (IDX_W + 2)'(i + 1);
        if (w_sum >= NP_W) begin
          w_sum = w_sum - NP_W;
        end
        w_cand = w_sum[IDX_W-1:0];
      end
      if (!w_gnt_valid && w_req[w_cand]) begin
        w_gnt_valid = 1'b1;
        w_gnt_idx   = w_cand;
      end
    end
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_n) begin
      r_state <= S_INIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_INIT: begin
        if (local_init_done) w_state_nxt = S_IDLE;
      end
      S_IDLE: begin
        if (!local_init_done)  w_state_nxt = S_INIT;
        else if (w_gnt_valid)  w_state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        if (avl_waitrequest_n) w_state_nxt = r_is_write ? S_DONE : S_RDWAIT;
      end
      S_RDWAIT: begin
        if (avl_readdatavalid || w_timeout) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        // A calibration loss seen mid-transaction is honoured only here.
        w_state_nxt = local_init_done ? S_IDLE : S_INIT;
      end
      default: w_state_nxt = S_INIT;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_n) begin
      r_grant          <= '0;
      r_last_grant     <= LAST_INIT;
      r_is_write       <= 1'b0;
      r_avl_address    <= '0;
      r_avl_writedata  <= '0;
      r_avl_read       <= 1'b0;
      r_avl_write      <= 1'b0;
      r_avl_burstbegin <= 1'b0;
      r_cnt            <= '0;
      r_rdata          <= '0;
      r_done           <= '0;
      r_err            <= '0;
    end else begin
      // Completion flags are set on the edge into DONE and live one cycle.
      r_done <= '0;
      r_err  <= '0;
      case (r_state)
        S_IDLE: begin
          if (local_init_done && w_gnt_valid) begin
            r_grant          <= w_gnt_idx;
            r_is_write       <= port_wreq[w_gnt_idx];
            r_avl_address    <= AVL_ADDR_W'(w_addr_arr[w_gnt_idx] >> WORD_SHIFT);
            r_avl_writedata  <= w_wdata_arr[w_gnt_idx];
            r_avl_write      <= port_wreq[w_gnt_idx];
            r_avl_read       <= ~port_wreq[w_gnt_idx];
            r_avl_burstbegin <= 1'b1;
          end
        end
        S_ISSUE: begin
          r_avl_burstbegin <= 1'b0;
          if (avl_waitrequest_n) begin
            r_avl_read  <= 1'b0;
            r_avl_write <= 1'b0;
            r_cnt       <= '0;
            if (r_is_write) r_done[r_grant] <= 1'b1;
          end
        end
        S_RDWAIT: begin
          if (avl_readdatavalid) begin
            r_rdata[r_grant] <= avl_readdata;
            r_done[r_grant]  <= 1'b1;
          end else if (w_timeout) begin
            r_done[r_grant] <= 1'b1;
            r_err[r_grant]  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          r_last_grant <= r_grant;
        end
        default: ;
      endcase
    end
  end

  assign port_rdata     = r_rdata;
  assign port_done      = r_done;
  assign port_err       = r_err;
  assign avl_address    = r_avl_address;
  assign avl_read       = r_avl_read;
  assign avl_write      = r_avl_write;
  assign avl_burstbegin = r_avl_burstbegin;
  assign avl_writedata  = r_avl_writedata;
  assign c_state        = r_state;

endmodule

// File: tb/tb_lpddr2_multiport_bridge.sv
// tb/tb_lpddr2_multiport_bridge.sv - scoreboard bench for lpddr2_multiport_bridge
module tb_lpddr2_multiport_bridge;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, init_done, wr_n, rdv;
  logic [1:0]  rreq, wreq;
  logic [63:0] addr, wdata;
  logic [31:0] rd_bus;

  logic [63:0] port_rdata, fp_rdata;
  logic [1:0]  port_done, port_err, fp_done, fp_err;
  logic [26:0] avl_address, fp_address;
  logic        avl_read, avl_write, avl_bb, fp_read, fp_write, fp_bb;
  logic [31:0] avl_wd, fp_wd;
  logic [3:0]  c_state, fp_state;

  lpddr2_multiport_bridge #(.NUM_PORTS(2), .ARB_MODE(0), .RD_TIMEOUT(16)) dut (
    .iCLK(clk), .iRST_n(rst_n), .local_init_done(init_done),
    .port_rreq(rreq), .port_wreq(wreq), .port_addr(addr), .port_wdata(wdata),
    .port_rdata(port_rdata), .port_done(port_done), .port_err(port_err),
    .avl_waitrequest_n(wr_n), .avl_address(avl_address), .avl_read(avl_read),
    .avl_write(avl_write), .avl_burstbegin(avl_bb), .avl_writedata(avl_wd),
    .avl_readdatavalid(rdv), .avl_readdata(rd_bus), .c_state(c_state)
  );

  lpddr2_multiport_bridge #(.NUM_PORTS(2), .ARB_MODE(1), .RD_TIMEOUT(16)) dut_fp (
    .iCLK(clk), .iRST_n(rst_n), .local_init_done(init_done),
    .port_rreq(rreq), .port_wreq(wreq), .port_addr(addr), .port_wdata(wdata),
    .port_rdata(fp_rdata), .port_done(fp_done), .port_err(fp_err),
    .avl_waitrequest_n(wr_n), .avl_address(fp_address), .avl_read(fp_read),
    .avl_write(fp_write), .avl_burstbegin(fp_bb), .avl_writedata(fp_wd),
    .avl_readdatavalid(rdv), .avl_readdata(rd_bus), .c_state(fp_state)
  );

  typedef struct {
    int          port;
    logic        err;
    logic [63:0] rdata;
  } exp_t;

  exp_t            exp_q[$];
  int              fp_q[$];
  logic [1:0][31:0] m_rdata;
  bit              arb_phase = 1'b0;
  int              n_checks  = 0;
  int              n_fail    = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (|port_done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'(port_done), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("done_port", 64'(port_done), 64'd1 << e.port);
        check("done_err", 64'(port_err), 64'(e.err) << e.port);
        check("done_rdata", port_rdata, e.rdata);
      end
    end
  end

  always @(negedge clk) begin
    int p;
    if (arb_phase && (|fp_done)) begin
      if (fp_q.size() == 0) begin
        check("fp_unexpected_done", 64'(fp_done), 64'd0);
      end else begin
        p = fp_q.pop_front();
        check("fp_grant", 64'(fp_done), 64'd1 << p);
      end
    end
  end

  task automatic expect_done(input int p, input logic err, input bit upd, input logic [31:0] d);
    exp_t e;
    if (upd) m_rdata[p] = d;
    e.port  = p;
    e.err   = err;
    e.rdata = m_rdata;
    exp_q.push_back(e);
  endtask

  task automatic start_req(input int p, input bit wr, input logic [31:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    addr[p*32 +: 32]  = a;
    wdata[p*32 +: 32] = d;
    if (wr) wreq[p] = 1'b1;
    else    rreq[p] = 1'b1;
  endtask

  task automatic wait_done(input string tag, output int cyc, output int rdw);
    cyc = 0;
    rdw = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (c_state == 4'd3) rdw++;
    end while (!(|port_done) && cyc < 100);
    check({tag, "_done_seen"}, 64'(|port_done), 64'd1);
  endtask

  task automatic do_write(input string tag, input int p, input logic [31:0] a, input logic [31:0] d);
    int cyc, rdw;
    expect_done(p, 1'b0, 1'b0, 32'h0);
    start_req(p, 1'b1, a, d);
    wait_done(tag, cyc, rdw);
    wreq = '0;
    check({tag, "_latency"}, 64'(cyc), 64'd3);
  endtask

  task automatic do_read(input string tag, input int p, input logic [31:0] a, input logic [31:0] d, input int dly);
    int cyc, rdw;
    expect_done(p, 1'b0, 1'b1, d);
    start_req(p, 1'b0, a, 32'h0);
    @(negedge clk);
    @(negedge clk);
    check({tag, "_avl_read"}, 64'(avl_read), 64'd1);
    check({tag, "_avl_addr"}, 64'(avl_address), 64'(a >> 2));
    repeat (dly) @(negedge clk);
    rdv    = 1'b1;
    rd_bus = d;
    wait_done(tag, cyc, rdw);
    rdv  = 1'b0;
    rreq = '0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    rreq  = '0;
    wreq  = '0;
    rdv   = 1'b0;
    wr_n  = 1'b1;
    repeat (2) @(negedge clk);
    m_rdata = '0;
    rst_n   = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc, rdw;
    rst_n = 1'b0; init_done = 1'b0; wr_n = 1'b1; rdv = 1'b0;
    rreq = '0; wreq = '0; addr = '0; wdata = '0; rd_bus = '0;
    m_rdata = '0;

    // Reset state and calibration hand-off
    repeat (3) @(negedge clk);
    check("rst_state", 64'(c_state), 64'd0);
    check("rst_avl", {29'd0, avl_read, avl_write, avl_bb, avl_address}, 64'd0);
    check("rst_wdata", 64'(avl_wd), 64'd0);
    check("rst_rdata", port_rdata, 64'd0);
    check("rst_done_err", 64'({port_done, port_err}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("init_hold", 64'(c_state), 64'd0);
    init_done = 1'b1;
    @(negedge clk);
    check("init_to_idle", 64'(c_state), 64'd1);

    // Port0 write, step by step
    expect_done(0, 1'b0, 1'b0, 32'h0);
    start_req(0, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF);
    @(negedge clk);
    check("wr_idle", 64'(c_state), 64'd1);
    @(negedge clk);
    check("wr_issue_state", 64'(c_state), 64'd2);
    check("wr_cmd", {61'd0, avl_write, avl_read, avl_bb}, 64'b101);
    check("wr_addr", 64'(avl_address), 64'h40);
    check("wr_data", 64'(avl_wd), 64'hDEAD_BEEF);
    @(negedge clk);
    check("wr_latency_done", 64'(port_done), 64'b01);
    check("wr_cmd_dropped", {62'd0, avl_write, avl_bb}, 64'd0);
    wreq = '0;

    // Reads: the port1 read must leave port0's slice intact
    do_read("rd_p0", 0, 32'h0000_0010, 32'hA5A5_0001, 2);
    do_read("rd_p1", 1, 32'h0000_0020, 32'h1234_5678, 5);

    // Stalled command: waitrequest_n low for 7 cycles, accepted on cycle 8
    wr_n = 1'b0;
    expect_done(0, 1'b0, 1'b1, 32'hCAFE_0000);
    start_req(0, 1'b0, 32'h0000_0200, 32'h0);
    @(negedge clk);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check("stall_state", 64'(c_state), 64'd2);
      check("stall_read", 64'(avl_read), 64'd1);
      check("stall_addr", 64'(avl_address), 64'h80);
      check("stall_bb", 64'(avl_bb), 64'(k == 1));
      if (k == 8) wr_n = 1'b1;
    end
    @(negedge clk);
    check("stall_accepted", {60'd0, c_state}, 64'd3);
    check("stall_read_off", 64'(avl_read), 64'd0);
    rdv = 1'b1;
    rd_bus = 32'hCAFE_0000;
    wait_done("stall", cyc, rdw);
    rdv  = 1'b0;
    rreq = '0;

    // Read timeout, then a normal transaction
    expect_done(1, 1'b1, 1'b0, 32'h0);
    start_req(1, 1'b0, 32'h0000_0300, 32'h0);
    wait_done("timeout", cyc, rdw);
    rreq = '0;
    check("timeout_rdwait_cycles", 64'(rdw), 64'd16);
    check("timeout_total_cycles", 64'(cyc), 64'd19);
    do_write("after_timeout", 0, 32'h0000_0400, 32'h0BAD_F00D);

    // Arbitration with both ports requesting continuously
    apply_reset();
    check("arb_ready", 64'(c_state), 64'd1);
    arb_phase = 1'b1;
    for (int t = 0; t < 4; t++) begin
      expect_done(t % 2, 1'b0, 1'b0, 32'h0);
      fp_q.push_back(0);
    end
    @(posedge clk);
    #1;
    addr  = {32'h0000_2000, 32'h0000_1000};
    wdata = {32'h2222_2222, 32'h1111_1111};
    wreq  = 2'b11;
    for (int t = 0; t < 4; t++) wait_done("arb", cyc, rdw);
    wreq = '0;
    @(negedge clk);
    arb_phase = 1'b0;
    check("arb_rr_drained", 64'(exp_q.size()), 64'd0);
    check("arb_fp_drained", 64'(fp_q.size()), 64'd0);

    // Reset while a read is outstanding
    start_req(0, 1'b0, 32'h0000_0500, 32'h0);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (c_state != 4'd3 && cyc < 20);
    check("rst_reached_rdwait", 64'(c_state), 64'd3);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_rdwait_state", 64'(c_state), 64'd0);
    check("rst_rdwait_read", 64'(avl_read), 64'd0);
    check("rst_rdwait_done", 64'(port_done), 64'd0);
    rreq    = '0;
    m_rdata = '0;
    rst_n   = 1'b1;
    @(negedge clk);
    check("rst_recover", 64'(c_state), 64'd1);

    // Calibration loss while idle
    init_done = 1'b0;
    @(negedge clk);
    check("idle_init_drop", 64'(c_state), 64'd0);
    init_done = 1'b1;
    @(negedge clk);
    check("idle_init_back", 64'(c_state), 64'd1);

    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lpddr2_multiport_bridge.md
Name: lpddr2_multiport_bridge

Overview:
Parametrised successor to the single-port LPDDR2 Avalon adapter. Arbitrates NUM_PORTS level-held read/write requesters (CPU data path, disk DMA, debug) onto one Avalon-MM master port of the LPDDR2 controller. Runs in the controller's afi_half_clk domain. Adds selectable arbitration, a per-port done pulse, and a read-timeout error the single-port adapter lacks.

Parameters:
NUM_PORTS, 2, number of requester ports (1..8)
DATA_W, 32, data width of ports and Avalon bus
ADDR_W, 32, requester byte-address width
AVL_ADDR_W, 27, Avalon word-address width
WORD_SHIFT, 2, right shift from byte address to word address
ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins)
RD_TIMEOUT, 1023, max cycles from read acceptance to readdatavalid before error

Ports:
iCLK  in  1  clock (afi_half_clk)
iRST_n  in  1  reset, synchronous, active-low
local_init_done  in  1  controller calibration complete
port_rreq  in  NUM_PORTS  per-port read request, level, held until done
port_wreq  in  NUM_PORTS  per-port write request, level, held until done
port_addr  in  NUM_PORTS*ADDR_W  packed byte addresses, port i at [i*ADDR_W +: ADDR_W]
port_wdata  in  NUM_PORTS*DATA_W  packed write data
port_rdata  out  NUM_PORTS*DATA_W  packed read data, per-port holding register
port_done  out  NUM_PORTS  one-cycle completion pulse
port_err  out  NUM_PORTS  read timeout flag, valid with port_done
avl_waitrequest_n  in  1  controller ready (avl_ready)
avl_address  out  AVL_ADDR_W  word address
avl_read  out  1  read command
avl_write  out  1  write command
avl_burstbegin  out  1  first cycle of command
avl_writedata  out  DATA_W  write data
avl_readdatavalid  in  1  read data valid
avl_readdata  in  DATA_W  read data
c_state  out  4  current FSM state encoding

Behaviour:
- Reset (iRST_n=0 at posedge): state INIT; every output 0, including port_rdata, port_done, port_err, avl_*, and the round-robin pointer (last grant = NUM_PORTS-1). Any in-flight Avalon command is abandoned.
- States and c_state encoding: INIT=0, IDLE=1, ISSUE=2, RDWAIT=3, DONE=4. c_state==1 means ready; the top level gates CPU enable on it.
- INIT: move to IDLE once local_init_done=1.
- IDLE: if local_init_done=0, go to INIT. Otherwise a port requests when rreq|wreq.
  - ARB_MODE=0: grant the first requesting port searching from last_grant+1, wrapping modulo NUM_PORTS.
  - ARB_MODE=1: grant the lowest requesting index.
  - On grant: latch grant index, op (write if wreq=1, else read; write wins if both), avl_address = port_addr >> WORD_SHIFT truncated to AVL_ADDR_W, and wdata. Go to ISSUE. No request means stay.
- ISSUE: avl_read or avl_write=1 with address and data stable. avl_burstbegin=1 only in the first ISSUE cycle.
  - The command is accepted on a cycle where avl_waitrequest_n=1; deassert avl_read/avl_write the next cycle.
  - Accepted write goes to DONE. Accepted read goes to RDWAIT and clears the timeout counter.
- RDWAIT: counter increments each cycle.
  - readdatavalid=1: capture avl_readdata into the granted port's rdata slice and go to DONE, err=0.
  - Counter reaches RD_TIMEOUT first: go to DONE, err=1, rdata unchanged.
  - readdatavalid and timeout in the same cycle: data wins, err=0.
- DONE: port_done[grant]=1 for exactly one cycle, and port_err[grant]=err. Update last_grant, return to IDLE.
  - The requester must deassert its request in the cycle after port_done. Minimum request-to-done latency is 3 cycles for a write with waitrequest_n=1.
- local_init_done falling during ISSUE or RDWAIT: the transaction completes normally, then INIT is entered on return from DONE.
- Request changes while a port is granted are ignored until DONE; latched address and data are used.
- port_rdata slices of non-granted ports never change except on reset.
- Only one Avalon command is outstanding at any time.

Test Plan:
- Reset then local_init_done=1: c_state 0→1, all outputs 0. Port0 write addr 0x0000_0100, data 0xDEADBEEF, waitrequest_n=1 → avl_address=0x40, avl_write and burstbegin high for 1 cycle, port_done[0] 3 cycles after request.
- Port1 read addr 0x20, readdatavalid 5 cycles after acceptance with 0x12345678 → port_rdata[63:32]=0x12345678, port_done[1] pulse, port_rdata[31:0] unchanged.
- ARB_MODE=0, both ports request continuously for 4 transactions → grants 0,1,0,1. ARB_MODE=1, same stimulus → grants 0,0,0,0.
- waitrequest_n low for 7 cycles during ISSUE → avl_read held with stable address for 7 cycles, burstbegin only in the first; accepted on cycle 8.
- Read with no readdatavalid, RD_TIMEOUT=16 → port_done with port_err=1 after 16 RDWAIT cycles; next transaction proceeds normally.
- iRST_n=0 during RDWAIT → next cycle c_state=0, avl_read=0, no port_done; local_init_done drop in IDLE → INIT.
